imem_fetch_unit: RTL and testbench

IMEM_FETCH_UNIT -- requirements
Module: imem_fetch_unit

---
 rtl/imem_fetch_unit.sv | 158 +++++++++++++++
 tb/tb_imem_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_unit.sv
// rtl/imem_fetch_unit.sv - instruction memory with a one-deep fetch response stage and program-load port
//
// Purpose:
//   Word-organised instruction store. Fetches are accepted on a valid/ready
//   handshake and answered one cycle later from a registered response stage
//   that holds its data while the consumer stalls. A separate load port
//   writes program words. While loading, fetches are refused.
//
// Ports:
//   clk, reset                 single clock, asynchronous active-high reset
//   req_valid/req_ready/req_addr   fetch request (byte address)
//   rsp_valid/rsp_ready            fetch response handshake
//   rsp_instr/rsp_fault            response payload
//   flush                      drops the pending response and any same-cycle accept
//   ld_en/ld_addr/ld_data      program-load write port (byte address)
//   fetch_count                responses consumed since reset, wraps at 2^32
//
// Configuration:
//   IMEM_BOUNDS_CHECK_EN  when defined, misaligned or out-of-range fetches
//                         answer with rsp_fault=1 and NOP_WORD, and such loads
//                         are dropped; when undefined, address bits [1:0] are
//                         ignored and the word index wraps modulo DEPTH_WORDS.

module imem_fetch_unit #(
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [DATA_W-1:0] NOP_WORD    = 32'h00000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic              rsp_fault,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [31:0]       fetch_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic {
        FETCH = 1'b0,
        LOAD  = 1'b1
    } state_e;

    // Words are stored XORed with NOP_WORD so that the array's all-zero
    // power-up contents read back as NOP_WORD without any init or reset.
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    state_e            state_q, state_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_instr_q, rsp_instr_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic [31:0]       fetch_count_q, fetch_count_d;

    logic [ADDR_W-1:0] req_word;
    logic [ADDR_W-1:0] ld_word;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  ld_idx;
    logic              req_oob;
    logic              ld_oob;
    logic              ld_we;
    logic              accept;
    logic              ready_int;

    assign req_word = req_addr >> 2;
    assign ld_word  = ld_addr >> 2;
    assign req_idx  = req_word[IDX_W-1:0];
    assign ld_idx   = ld_word[IDX_W-1:0];

`ifdef IMEM_BOUNDS_CHECK_EN
    assign req_oob = (req_addr[1:0] != 2'b00) || ((req_word >> IDX_W) != '0);
    assign ld_oob  = (ld_addr[1:0] != 2'b00) || ((ld_word >> IDX_W) != '0);
`else
    // Index wraps modulo DEPTH_WORDS; the discarded address bits are
    // collected here only so they are visibly intentionally unused.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[1:0], ld_addr[1:0],
                                req_word[ADDR_W-1:IDX_W], ld_word[ADDR_W-1:IDX_W]};
    assign req_oob = 1'b0;
    assign ld_oob  = 1'b0;
`endif

    // Writes are blocked while reset is held so reset never changes contents.
    assign ld_we = ld_en && !reset && !ld_oob;

    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem_q[ld_idx] <= ld_data ^ NOP_WORD;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (ld_en)  state_d = LOAD;
            LOAD:    if (!ld_en) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // The state we are heading to decides readiness, so the first cycle with
    // ld_en low already accepts fetches, and any cycle with ld_en high refuses.
    assign ready_int = !reset && (state_d == FETCH) && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && ready_int;

    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_instr_d   = rsp_instr_q;
        rsp_fault_d   = rsp_fault_q;
        fetch_count_d = fetch_count_q;

        if (rsp_valid_q && rsp_ready && !flush) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end

        // Flush dominates both a new accept and a consume in the same cycle.
        if (flush) begin
            rsp_valid_d = 1'b0;
        end else if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = req_oob;
            rsp_instr_d = req_oob ? NOP_WORD : (mem_q[req_idx] ^ NOP_WORD);
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            rsp_valid_q   <= 1'b0;
            rsp_instr_q   <= NOP_WORD;
            rsp_fault_q   <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_instr_q   <= rsp_instr_d;
            rsp_fault_q   <= rsp_fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign req_ready   = ready_int;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_instr   = rsp_instr_q;
    assign rsp_fault   = rsp_fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb/tb_imem_fetch_unit.sv - self-checking bench for imem_fetch_unit

module tb_imem_fetch_unit;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h00000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_fault;
    logic        flush;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    imem_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_instr   (rsp_instr),
        .rsp_fault   (rsp_fault),
        .flush       (flush),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .fetch_count (fetch_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: memory as a plain array, response as a one-entry slot.
    logic [31:0] m_mem [DEPTH];
    logic        m_valid;
    logic [31:0] m_instr;
    logic        m_fault;
    logic [31:0] m_count;
    logic        m_ready;
    logic        s_ready;

    function automatic logic m_bad(input logic [31:0] a);
`ifdef IMEM_BOUNDS_CHECK_EN
        return (a % 4 != 0) || (a / 4 >= DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_instr = NOP;
        m_fault = 1'b0;
        m_count = 32'd0;
    endtask

    // One clock: drive inputs, sample req_ready before the edge, advance the
    // model at the edge, leave time at edge+1 for output checks.
    task automatic cyc(input logic le, input logic [31:0] la, input logic [31:0] ld,
                       input logic rv, input logic [31:0] ra, input logic rr, input logic fl);
        logic was_valid;
        ld_en = le; ld_addr = la; ld_data = ld;
        req_valid = rv; req_addr = ra; rsp_ready = rr; flush = fl;
        #2;
        s_ready = req_ready;
        m_ready = !reset && !le && (!m_valid || rr);
        @(posedge clk);
        if (!reset) begin
            was_valid = m_valid;
            if (le && !m_bad(la)) m_mem[m_idx(la)] = ld;
            if (was_valid && rr && !fl) m_count = m_count + 32'd1;
            if (fl) begin
                m_valid = 1'b0;
            end else if (rv && m_ready) begin
                m_valid = 1'b1;
                m_fault = m_bad(ra);
                m_instr = m_fault ? NOP : m_mem[m_idx(ra)];
            end else if (rr) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " req_ready"}, {31'd0, s_ready}, {31'd0, m_ready});
        chk({tag, " rsp_valid"}, {31'd0, rsp_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk({tag, " rsp_instr"}, rsp_instr, m_instr);
            chk({tag, " rsp_fault"}, {31'd0, rsp_fault}, {31'd0, m_fault});
        end
        chk({tag, " fetch_count"}, fetch_count, m_count);
    endtask

    typedef struct {
        logic        le;
        logic [31:0] la;
        logic [31:0] ld;
        logic        rv;
        logic [31:0] ra;
        logic        rr;
        logic        fl;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_instr;
        logic        e_fault;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic le, input logic [31:0] la, input logic [31:0] ld,
                                input logic rv, input logic [31:0] ra, input logic rr,
                                input logic fl, input logic e_ready, input logic e_valid,
                                input logic [31:0] e_instr, input logic e_fault,
                                input logic [31:0] e_count);
        vec_t v;
        v.le = le; v.la = la; v.ld = ld; v.rv = rv; v.ra = ra; v.rr = rr; v.fl = fl;
        v.e_ready = e_ready; v.e_valid = e_valid; v.e_instr = e_instr;
        v.e_fault = e_fault; v.e_count = e_count;
        vecs.push_back(v);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 31)) * 4;
        if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 9) == 0) a = a + 32'd4096 * 32'($urandom_range(1, 3));
        return a;
    endfunction

    logic [31:0] i_oob;
    logic        f_oob;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
        model_reset();
`ifdef IMEM_BOUNDS_CHECK_EN
        i_oob = 32'h00000000; f_oob = 1'b1;
`else
        i_oob = 32'h8C100004; f_oob = 1'b0;
`endif
        //  le la      ld            rv ra       rr fl  rdy vld instr         flt    cnt
        add(1, 32'd0,  32'h8C100004, 0, 32'd0,    0, 0,  0,  0, 32'h00000000, 0,     0);
        add(1, 32'd4,  32'h11111111, 0, 32'd0,    0, 0,  0,  0, 32'h00000000, 0,     0);
        add(1, 32'd8,  32'h22222222, 0, 32'd0,    0, 0,  0,  0, 32'h00000000, 0,     0);
        add(0, 32'd0,  32'd0,        1, 32'd0,    1, 0,  1,  1, 32'h8C100004, 0,     0);
        add(0, 32'd0,  32'd0,        1, 32'd4,    1, 0,  1,  1, 32'h11111111, 0,     1);
        add(0, 32'd0,  32'd0,        1, 32'd8,    1, 0,  1,  1, 32'h22222222, 0,     2);
        add(0, 32'd0,  32'd0,        0, 32'd0,    1, 0,  1,  0, 32'h22222222, 0,     3);
        add(0, 32'd0,  32'd0,        1, 32'd4,    0, 0,  1,  1, 32'h11111111, 0,     3);
        add(0, 32'd0,  32'd0,        1, 32'd0,    0, 0,  0,  1, 32'h11111111, 0,     3);
        add(0, 32'd0,  32'd0,        1, 32'd0,    0, 0,  0,  1, 32'h11111111, 0,     3);
        add(0, 32'd0,  32'd0,        1, 32'd0,    0, 0,  0,  1, 32'h11111111, 0,     3);
        add(0, 32'd0,  32'd0,        0, 32'd0,    1, 0,  1,  0, 32'h11111111, 0,     4);
        add(0, 32'd0,  32'd0,        1, 32'd8,    1, 1,  1,  0, 32'h11111111, 0,     4);
        add(0, 32'd0,  32'd0,        1, 32'd8,    0, 0,  1,  1, 32'h22222222, 0,     4);
        add(0, 32'd0,  32'd0,        1, 32'd0,    1, 1,  1,  0, 32'h22222222, 0,     4);
        add(0, 32'd0,  32'd0,        1, 32'd2,    1, 0,  1,  1, i_oob,        f_oob, 4);
        add(0, 32'd0,  32'd0,        1, 32'd4096, 1, 0,  1,  1, i_oob,        f_oob, 5);
        add(0, 32'd0,  32'd0,        0, 32'd0,    1, 0,  1,  0, i_oob,        f_oob, 6);
        add(0, 32'd0,  32'd0,        1, 32'd8,    0, 0,  1,  1, 32'h22222222, 0,     6);
        add(1, 32'd12, 32'h33333333, 0, 32'd0,    0, 0,  0,  1, 32'h22222222, 0,     6);
        add(1, 32'd16, 32'h44444444, 0, 32'd0,    1, 0,  0,  0, 32'h22222222, 0,     7);
        add(0, 32'd0,  32'd0,        1, 32'd16,   1, 0,  1,  1, 32'h44444444, 0,     7);
        add(0, 32'd0,  32'd0,        1, 32'd12,   1, 0,  1,  1, 32'h33333333, 0,     8);
        add(0, 32'd0,  32'd0,        0, 32'd0,    1, 0,  1,  0, 32'h33333333, 0,     9);

        // Reset with a request presented: nothing accepted, outputs at reset values.
        reset = 1'b1; req_valid = 1'b1; req_addr = 32'd0; rsp_ready = 1'b1; flush = 1'b0;
        ld_en = 1'b0; ld_addr = 32'd0; ld_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst rsp_instr", rsp_instr, NOP);
        chk("rst rsp_fault", {31'd0, rsp_fault}, 32'd0);
        chk("rst fetch_count", fetch_count, 32'd0);
        reset = 1'b0; req_valid = 1'b0;
        #1;
        chk("post-rst req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].le, vecs[i].la, vecs[i].ld, vecs[i].rv, vecs[i].ra, vecs[i].rr, vecs[i].fl);
            chk($sformatf("v%0d req_ready", i), {31'd0, s_ready}, {31'd0, vecs[i].e_ready});
            chk($sformatf("v%0d rsp_valid", i), {31'd0, rsp_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d rsp_instr", i), rsp_instr, vecs[i].e_instr);
            chk($sformatf("v%0d rsp_fault", i), {31'd0, rsp_fault}, {31'd0, vecs[i].e_fault});
            chk($sformatf("v%0d fetch_count", i), fetch_count, vecs[i].e_count);
        end

        // Reset mid-load with a response pending: outputs clear, loaded words survive.
        cyc(0, 32'd0, 32'd0, 1, 32'd8, 0, 0);
        chk_model("pend");
        for (int w = 0; w < 4; w++) begin
            cyc(1, 32'(w * 4), 32'hA5A50000 + 32'(w), 0, 32'd0, 0, 0);
            chk_model($sformatf("ld%0d", w));
        end
        ld_en = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        chk("mid rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid rst rsp_instr", rsp_instr, NOP);
        chk("mid rst rsp_fault", {31'd0, rsp_fault}, 32'd0);
        chk("mid rst fetch_count", fetch_count, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int w = 0; w < 4; w++) begin
            cyc(0, 32'd0, 32'd0, 1, 32'(w * 4), 1, 0);
            chk($sformatf("reload w%0d", w), rsp_instr, 32'hA5A50000 + 32'(w));
            chk_model($sformatf("reload%0d", w));
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 9) == 0, rand_addr(), $urandom,
                $urandom_range(0, 9) < 6, rand_addr(),
                $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
